// File: rtl/pcpu_pkg.sv
// Shared types and constants for the pipelined CPU fetch front end.
`timescale 1ns/1ps
package pcpu_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_BUSY  = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/pcpu_sync_fifo.sv
// Synchronous FIFO with flush; head data comes straight from the storage registers.
`timescale 1ns/1ps
module pcpu_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [WIDTH-1:0]               rdata
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pcpu_fetch_queue.sv
// Instruction fetch front end: single-outstanding imem requester feeding a prefetch queue,
// with redirect flushing the queue and discarding any in-flight response.
`timescale 1ns/1ps
module pcpu_fetch_queue
    import pcpu_pkg::*;
#(
    parameter int unsigned    XLEN     = XLEN_DEF,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic                        imem_ready,
    input  logic [31:0]                 imem_rdata,
    input  logic                        redirect,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        if_valid,
    output logic [31:0]                 if_inst,
    output logic [XLEN-1:0]             if_pc,
    output logic [XLEN-1:0]             if_pc4,
    input  logic                        id_ready,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            push, pop, q_full, q_empty;
    logic [CntW:0]   occ_after;
    logic [XLEN+31:0] head;

    assign imem_req  = (state_q != FS_IDLE);
    assign imem_addr = addr_q;
    assign pop       = if_valid & id_ready;
    assign if_valid  = ~q_empty;
    assign {if_pc, if_inst} = head;
    assign if_pc4    = if_pc + XLEN'(INST_BYTES);

    // Occupancy after this cycle's push, used to decide on a back-to-back request.
    assign occ_after = {1'b0, q_count} + (CntW+1)'(1) - (CntW+1)'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (!q_full) begin
                    addr_d  = fetch_pc_q;
                    state_d = FS_BUSY;
                end
            end
            FS_BUSY: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ready ? FS_IDLE : FS_DRAIN;
                end else if (imem_ready) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_q + XLEN'(INST_BYTES);
                    if (occ_after < (CntW+1)'(DEPTH)) begin
                        addr_d = addr_q + XLEN'(INST_BYTES);
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
            end
            FS_DRAIN: begin
                if (redirect)   fetch_pc_d = redirect_pc;
                if (imem_ready) state_d    = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    pcpu_sync_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_addr, imem_rdata}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .rdata (head)
    );

endmodule

// File: tb/tb_pcpu_fetch_queue.sv
// Directed self-checking bench for pcpu_fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0).
`timescale 1ns/1ps
module tb_pcpu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory model: word content is a fixed function of the requested address.
    assign imem_rdata = inst_of(imem_addr);

    pcpu_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .id_ready    (id_ready),
        .q_count     (q_count)
    );

    typedef struct {
        logic        id_rdy;
        logic        mem_rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic idr, input logic mr, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input logic [2:0] cnt);
        vec_t r;
        r.id_rdy = idr; r.mem_rdy = mr; r.e_req = req; r.e_addr = addr;
        r.e_valid = v; r.e_pc = pc; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!imem_req && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!if_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("valid_wait", {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        // Zero-wait streaming, then fill to DEPTH with ID stalled, then a single pop.
        vecs[0]  = mk(1, 1, 0, 32'h00, 0, 32'h0, 0);
        vecs[1]  = mk(1, 1, 1, 32'h00, 0, 32'h0, 0);
        vecs[2]  = mk(1, 1, 1, 32'h04, 1, 32'h0, 1);
        vecs[3]  = mk(1, 1, 1, 32'h08, 1, 32'h4, 1);
        vecs[4]  = mk(0, 1, 1, 32'h0C, 1, 32'h8, 1);
        vecs[5]  = mk(0, 1, 1, 32'h10, 1, 32'h8, 2);
        vecs[6]  = mk(0, 1, 1, 32'h14, 1, 32'h8, 3);
        vecs[7]  = mk(0, 1, 0, 32'h14, 1, 32'h8, 4);
        vecs[8]  = mk(1, 1, 0, 32'h14, 1, 32'h8, 4);
        vecs[9]  = mk(0, 1, 0, 32'h14, 1, 32'hC, 3);
        vecs[10] = mk(0, 1, 1, 32'h18, 1, 32'hC, 3);
        vecs[11] = mk(0, 1, 0, 32'h18, 1, 32'hC, 4);

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0; id_ready = 1'b0;
        #12;
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_cnt",   {29'b0, q_count}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst",  if_inst, 32'h0);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_pc4",   if_pc4, 32'h4);

        do_reset();
        foreach (vecs[i]) begin
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i),    if_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_cnt", i),   {29'b0, q_count}, {29'b0, vecs[i].e_cnt});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_inst", i), if_inst, inst_of(vecs[i].e_pc));
                chk($sformatf("v%0d_pc4", i),  if_pc4, vecs[i].e_pc + 32'd4);
            end
            id_ready   = vecs[i].id_rdy;
            imem_ready = vecs[i].mem_rdy;
            @(negedge clk);
        end

        // Fill with ID stalled from reset, then resume at 0x10.
        do_reset();
        imem_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("fill_req", {31'b0, imem_req}, 32'd0);
        chk("fill_cnt", {29'b0, q_count}, 32'd4);
        chk("fill_pc",  if_pc, 32'h0);
        id_ready = 1'b1;
        @(negedge clk);
        wait_req(10);
        chk("resume_addr", imem_addr, 32'h10);

        // Slow memory, redirect one cycle after issue: response must be dropped.
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        chk("slow_req", {31'b0, imem_req}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        chk("drain_hold", imem_addr, 32'h0);
        @(negedge clk);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("drain_cnt",   {29'b0, q_count}, 32'd0);
        chk("drain_valid", {31'b0, if_valid}, 32'd0);
        wait_req(10);
        chk("drain_addr", imem_addr, 32'h100);

        // Redirect and response in the same BUSY cycle.
        do_reset();
        id_ready = 1'b1; imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0; imem_ready = 1'b0;
        chk("same_cnt",   {29'b0, q_count}, 32'd0);
        chk("same_valid", {31'b0, if_valid}, 32'd0);
        wait_req(10);
        chk("same_addr", imem_addr, 32'h200);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("same_pc",   if_pc, 32'h200);
        chk("same_inst", if_inst, inst_of(32'h200));

        // Several redirects while draining: the last one wins.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h2F0;
        @(negedge clk);
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h400;
        @(negedge clk);
        redirect = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("multi_cnt", {29'b0, q_count}, 32'd0);
        wait_valid(10);
        chk("multi_pc", if_pc, 32'h400);

        // Address wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid(10);
        chk("wrap_pc",  if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0);
        @(negedge clk);
        chk("wrap_next", if_pc, 32'h0);

        // Reset while a request is outstanding; a late response must be ignored.
        do_reset();
        @(negedge clk);
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_cnt", {29'b0, q_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("late_cnt",   {29'b0, q_count}, 32'd0);
        chk("late_valid", {31'b0, if_valid}, 32'd0);
        chk("late_req",   {31'b0, imem_req}, 32'd1);
        chk("late_addr",  imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
